// File: rtl/wsc_pkg.sv
// Shared definitions for the WSC sequencer: state encoding and default sizes.
package wsc_pkg;

  localparam int MAX_LEN_DEF = 32;
  localparam int LEN_W_DEF   = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    CAPTURE = 3'd2,
    SHIFT   = 3'd3,
    UPDATE  = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/wsc_shifter.sv
// Shift-in / shift-out register pair plus the bit counter for one WSC shift.
// Data is presented LSB first; captured WSO bits land at the counter index,
// so bits beyond the shift length stay zero.
module wsc_shifter #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               load,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic               shift_en,
  input  logic               wso,
  output logic               next_bit,
  output logic               done,
  output logic               len_zero,
  output logic [MAX_LEN-1:0] captured
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] sin_reg;
  logic [MAX_LEN-1:0] sout_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   cnt_reg;
  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] hit;

  assign len_clamped = (load_len > MAX_LEN_L) ? MAX_LEN_L : load_len;

  // One-hot decode of the counter selects which response bit takes WSO.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_hit
      assign hit[gi] = (cnt_reg == LEN_W'(gi));
    end
  endgenerate

  // While shifting, sin_reg[0] is the bit currently on WSI, so the bit for
  // the following cycle is sin_reg[1]; before the first shift it is sin_reg[0].
  assign next_bit = shift_en ? sin_reg[1] : sin_reg[0];
  assign done     = (cnt_reg == (len_reg - LEN_W'(1)));
  assign len_zero = (len_reg == '0);
  assign captured = sout_reg;

  // Load on command acceptance, then shift one bit per enabled cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      sin_reg  <= '0;
      sout_reg <= '0;
      len_reg  <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      sin_reg  <= load_data;
      sout_reg <= '0;
      len_reg  <= len_clamped;
      cnt_reg  <= '0;
    end else if (shift_en) begin
      sin_reg  <= {1'b0, sin_reg[MAX_LEN-1:1]};
      sout_reg <= sout_reg | ({MAX_LEN{wso}} & hit);
      if (!done) begin
        cnt_reg <= cnt_reg + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/wsc_sequencer.sv
// IEEE 1500 WSC initiator: runs select-setup, capture, shift, update for one
// command and returns the captured WSO bits. All WSC pins are registered and
// decoded from the next state so each strobe lines up with its state.
module wsc_sequencer
  import wsc_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               WRCK,
  input  logic               WRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_sel_wir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               SelectWIR,
  output logic               CaptureWR,
  output logic               ShiftWR,
  output logic               UpdateWR,
  output logic               WSI,
  input  logic               WSO
);

  state_t state_reg, state_next;

  logic               sel_wir_reg;
  logic               select_wir_reg, select_wir_next;
  logic               capture_wr_reg, capture_wr_next;
  logic               shift_wr_reg, shift_wr_next;
  logic               update_wr_reg, update_wr_next;
  logic               wsi_reg, wsi_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [MAX_LEN-1:0] rsp_data_reg;

  logic               accept;
  logic               sel_src;
  logic               next_bit;
  logic               shift_done;
  logic               len_zero;
  logic [MAX_LEN-1:0] captured;

  assign cmd_ready = (state_reg == IDLE) && !WRST;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_reg != IDLE);
  // On the acceptance edge the select value comes straight from the command.
  assign sel_src   = accept ? cmd_sel_wir : sel_wir_reg;

  assign SelectWIR = select_wir_reg;
  assign CaptureWR = capture_wr_reg;
  assign ShiftWR   = shift_wr_reg;
  assign UpdateWR  = update_wr_reg;
  assign WSI       = wsi_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;

  wsc_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk       (WRCK),
    .srst      (WRST),
    .load      (accept),
    .load_len  (cmd_len),
    .load_data (cmd_data),
    .shift_en  (state_reg == SHIFT),
    .wso       (WSO),
    .next_bit  (next_bit),
    .done      (shift_done),
    .len_zero  (len_zero),
    .captured  (captured)
  );

  // Next-state logic, then WSC pin values decoded from the next state.
  always_comb begin
    state_next      = state_reg;
    select_wir_next = 1'b0;
    capture_wr_next = 1'b0;
    shift_wr_next   = 1'b0;
    update_wr_next  = 1'b0;
    wsi_next        = 1'b0;
    rsp_valid_next  = 1'b0;

    case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = CAPTURE;
      CAPTURE: state_next = len_zero ? UPDATE : SHIFT;
      SHIFT:   state_next = shift_done ? UPDATE : SHIFT;
      UPDATE:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    case (state_next)
      SETUP:   select_wir_next = sel_src;
      CAPTURE: begin
        select_wir_next = sel_src;
        capture_wr_next = 1'b1;
      end
      SHIFT: begin
        select_wir_next = sel_src;
        shift_wr_next   = 1'b1;
        wsi_next        = next_bit;
      end
      UPDATE: begin
        select_wir_next = sel_src;
        update_wr_next  = 1'b1;
      end
      DONE:    rsp_valid_next = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset drops any command in flight.
  always_ff @(posedge WRCK) begin
    if (WRST) begin
      state_reg      <= IDLE;
      sel_wir_reg    <= 1'b0;
      select_wir_reg <= 1'b0;
      capture_wr_reg <= 1'b0;
      shift_wr_reg   <= 1'b0;
      update_wr_reg  <= 1'b0;
      wsi_reg        <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      select_wir_reg <= select_wir_next;
      capture_wr_reg <= capture_wr_next;
      shift_wr_reg   <= shift_wr_next;
      update_wr_reg  <= update_wr_next;
      wsi_reg        <= wsi_next;
      rsp_valid_reg  <= rsp_valid_next;
      if (accept) begin
        sel_wir_reg <= cmd_sel_wir;
      end
      if (state_next == DONE) begin
        rsp_data_reg <= captured;
      end
    end
  end

endmodule
